// File: rtl/tank_pkg.sv
// Shared types and constants for the enemy tank spawn scheduler.
// Holds the slot index type, spawn FSM states, LFSR constants and a popcount helper.
package tank_pkg;

   localparam int NUM_SLOTS = 4;

   typedef logic [1:0] slot_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SEL,
      REQ,
      DRAIN,
      DONE
   } spawn_state_t;

   // Galois form of x^8+x^6+x^5+x^4+1, shifting toward bit 0
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/enemy_spawn_ctrl_tick_sync.sv
// Two-flop synchroniser followed by a rising-edge detector producing a one-clock pulse.
// Used for the slow game tick and for the wave start button.
module tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse
);

   logic [2:0] sync_q;

   // sync_q[2] is the previous synchronised level, so the pulse is registered once more
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b000;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
         pulse  <= sync_q[1] & ~sync_q[2];
      end
   end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// Wave scheduler for the four enemy tank slots: budget, pacing, round-robin requests, kill count.
// Define SPAWN_LFSR_EN to add 0..7 pseudo-random ticks to each spawn gap.
module enemy_spawn_ctrl
   import tank_pkg::*;
#(
   parameter int TOTAL_TANKS = 20,
   parameter int SPAWN_GAP   = 8,
   parameter int ACK_TIMEOUT = 4,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_4hz,
   input  logic             start,
   input  logic [3:0]       tank_state,
   output logic [3:0]       tank_en,
   output logic [CNT_W-1:0] remaining,
   output logic [CNT_W-1:0] kills,
   output logic             busy,
   output logic             wave_done
);

   spawn_state_t state, state_next;

   logic         tick;
   logic         start_edge;
   slot_idx_t    rr_ptr;
   slot_idx_t    slot;
   slot_idx_t    pick;
   logic         found;
   logic [8:0]   gap_cnt;
   logic [8:0]   gap_limit;
   logic [3:0]   to_cnt;
   logic [3:0]   prev_state;
   logic [3:0]   fell;
   logic [CNT_W:0] kill_sum;
   logic         ack;
   logic         gap_hit;
   logic         to_hit;

   tick_sync u_tick_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (tick_4hz),
      .pulse    (tick)
   );

   tick_sync u_start_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (start),
      .pulse    (start_edge)
   );

`ifdef SPAWN_LFSR_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (tick) begin
         lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
      end
   end

   // The jitter is frozen for the whole gap so the limit cannot move under the counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_limit <= 9'(SPAWN_GAP);
      end else if (state_next == WAIT && state != WAIT) begin
         gap_limit <= 9'(SPAWN_GAP) + 9'(lfsr[2:0]);
      end
   end
`else
   assign gap_limit = 9'(SPAWN_GAP);
`endif

   // Round-robin search: scan backwards so the slot closest to rr_ptr wins
   always_comb begin
      slot_idx_t cand;
      found = 1'b0;
      pick  = rr_ptr;
      cand  = rr_ptr;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         cand = rr_ptr + slot_idx_t'(k);
         if (!tank_state[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign ack      = tank_state[slot];
   assign gap_hit  = tick && (gap_cnt == gap_limit - 9'd1);
   assign to_hit   = tick && (to_cnt == 4'(ACK_TIMEOUT - 1));
   assign fell     = prev_state & ~tank_state;
   assign kill_sum = {1'b0, kills} + (CNT_W + 1)'(popcount4(fell));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_edge) state_next = WAIT;
         WAIT: begin
            if (remaining == '0) state_next = DRAIN;
            else if (gap_hit)    state_next = SEL;
         end
         SEL:     state_next = found ? REQ : WAIT;
         REQ:     if (ack || to_hit) state_next = WAIT;
         DRAIN:   if (tank_state == 4'b0000) state_next = DONE;
         DONE:    if (start_edge) state_next = WAIT;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == WAIT) || (state == SEL) || (state == REQ) || (state == DRAIN);
      wave_done = (state == DONE);
   end

   // Kill overflow shows up in the extra top bit of kill_sum and clamps to all ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tank_en    <= 4'b0000;
         remaining  <= CNT_W'(TOTAL_TANKS);
         kills      <= '0;
         rr_ptr     <= '0;
         slot       <= '0;
         gap_cnt    <= '0;
         to_cnt     <= '0;
         prev_state <= 4'b0000;
      end else begin
         prev_state <= tank_state;

         if ((state == IDLE || state == DONE) && start_edge) begin
            kills <= '0;
         end else if (state != IDLE) begin
            kills <= kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
         end

         case (state)
            IDLE, DONE: begin
               if (start_edge) begin
                  remaining <= CNT_W'(TOTAL_TANKS);
                  gap_cnt   <= '0;
               end
            end
            WAIT: begin
               if (remaining != '0 && tick) begin
                  gap_cnt <= gap_hit ? 9'd0 : gap_cnt + 9'd1;
               end
            end
            SEL: begin
               if (found) begin
                  slot    <= pick;
                  tank_en <= 4'b0001 << pick;
                  to_cnt  <= '0;
               end
            end
            REQ: begin
               if (ack) begin
                  tank_en <= 4'b0000;
                  rr_ptr  <= slot + 2'd1;
                  if (remaining != '0) remaining <= remaining - 1'b1;
               end else if (tick) begin
                  if (to_hit) tank_en <= 4'b0000;
                  else        to_cnt  <= to_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed bench for enemy_spawn_ctrl: a default instance plus a two-tank instance for wave completion.
// Ticks and start are driven per instance so the two waves stay independent.
module tb_enemy_spawn_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_a = 1'b0, tick_b = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [3:0] ts_a = 4'b0000, ts_b = 4'b0000;
   logic [3:0] en_a, en_b;
   logic [5:0] rem_a, rem_b, kills_a, kills_b;
   logic       busy_a, busy_b, done_a, done_b;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   enemy_spawn_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .tick_4hz   (tick_a),
      .start      (start_a),
      .tank_state (ts_a),
      .tank_en    (en_a),
      .remaining  (rem_a),
      .kills      (kills_a),
      .busy       (busy_a),
      .wave_done  (done_a)
   );

   enemy_spawn_ctrl #(.TOTAL_TANKS(2)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .tick_4hz   (tick_b),
      .start      (start_b),
      .tank_state (ts_b),
      .tank_en    (en_b),
      .remaining  (rem_b),
      .kills      (kills_b),
      .busy       (busy_b),
      .wave_done  (done_b)
   );

   task automatic checkOutput(input string tag, input int unsigned got, input int unsigned exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input bit b, input logic [3:0] ts);
      if (b) ts_b = ts;
      else   ts_a = ts;
      @(negedge clk);
   endtask

   task automatic doTicks(input bit b, input int n);
      for (int i = 0; i < n; i++) begin
         if (b) tick_b = 1'b1;
         else   tick_a = 1'b1;
         repeat (4) @(negedge clk);
         tick_a = 1'b0;
         tick_b = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic pulseStart(input bit b);
      if (b) start_b = 1'b1;
      else   start_a = 1'b1;
      repeat (2) @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_tank_en", en_a, 0);
      checkOutput("rst_remaining", rem_a, 20);
      checkOutput("rst_kills", kills_a, 0);
      checkOutput("rst_busy", busy_a, 0);
      checkOutput("rst_wave_done", done_a, 0);
      checkOutput("rst_remaining2", rem_b, 2);

      // First request lands exactly on the eighth tick
      pulseStart(0);
      checkOutput("start_busy", busy_a, 1);
      doTicks(0, 7);
      checkOutput("gap7_tank_en", en_a, 0);
      doTicks(0, 1);
      checkOutput("gap8_tank_en", en_a, 4'b0001);
      checkOutput("gap8_remaining", rem_a, 20);

      applyStimulus(0, 4'b0001);
      checkOutput("ack0_tank_en", en_a, 0);
      checkOutput("ack0_remaining", rem_a, 19);
      doTicks(0, 7);
      checkOutput("rr_gap7_tank_en", en_a, 0);
      doTicks(0, 1);
      checkOutput("rr_slot1_tank_en", en_a, 4'b0010);

      // Unanswered request is abandoned on the fourth tick
      doTicks(0, 3);
      checkOutput("to3_tank_en", en_a, 4'b0010);
      doTicks(0, 1);
      checkOutput("to4_tank_en", en_a, 0);
      checkOutput("to4_remaining", rem_a, 19);
      doTicks(0, 8);
      checkOutput("retry_tank_en", en_a, 4'b0010);

      // All slots alive: no request across two full gaps
      applyStimulus(0, 4'b1111);
      checkOutput("ack1_remaining", rem_a, 18);
      checkOutput("ack1_tank_en", en_a, 0);
      doTicks(0, 8);
      checkOutput("full1_tank_en", en_a, 0);
      doTicks(0, 8);
      checkOutput("full2_tank_en", en_a, 0);
      applyStimulus(0, 4'b1011);
      checkOutput("kill1_kills", kills_a, 1);
      doTicks(0, 8);
      checkOutput("slot2_tank_en", en_a, 4'b0100);
      applyStimulus(0, 4'b1111);
      checkOutput("ack2_remaining", rem_a, 17);

      applyStimulus(0, 4'b0000);
      checkOutput("kill4_kills", kills_a, 5);

      pulseStart(0);
      checkOutput("busy_start_remaining", rem_a, 17);
      checkOutput("busy_start_kills", kills_a, 5);
      checkOutput("busy_start_busy", busy_a, 1);

      // Two-tank wave runs to completion on the second instance
      pulseStart(1);
      doTicks(1, 8);
      checkOutput("w2_first_tank_en", en_b, 4'b0001);
      applyStimulus(1, 4'b0001);
      checkOutput("w2_ack0_remaining", rem_b, 1);
      doTicks(1, 8);
      checkOutput("w2_second_tank_en", en_b, 4'b0010);
      applyStimulus(1, 4'b0011);
      checkOutput("w2_ack1_remaining", rem_b, 0);
      @(negedge clk);
      checkOutput("w2_drain_busy", busy_b, 1);
      checkOutput("w2_drain_done", done_b, 0);
      applyStimulus(1, 4'b0000);
      @(negedge clk);
      checkOutput("w2_done_wave_done", done_b, 1);
      checkOutput("w2_done_busy", busy_b, 0);
      checkOutput("w2_done_kills", kills_b, 2);

      // Kill counter saturation while parked in DONE
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1, 4'b1111);
         applyStimulus(1, 4'b0000);
      end
      checkOutput("sat_kills62", kills_b, 62);
      applyStimulus(1, 4'b1111);
      applyStimulus(1, 4'b0000);
      checkOutput("sat_kills63", kills_b, 63);
      applyStimulus(1, 4'b1111);
      applyStimulus(1, 4'b0000);
      checkOutput("sat_kills_hold", kills_b, 63);

      pulseStart(1);
      checkOutput("restart_remaining", rem_b, 2);
      checkOutput("restart_kills", kills_b, 0);
      checkOutput("restart_wave_done", done_b, 0);
      checkOutput("restart_busy", busy_b, 1);

      // Pointer wraps to slot 3, then reset lands mid-request
      doTicks(0, 8);
      checkOutput("slot3_tank_en", en_a, 4'b1000);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_tank_en", en_a, 0);
      checkOutput("midrst_remaining", rem_a, 20);
      checkOutput("midrst_kills", kills_a, 0);
      checkOutput("midrst_busy", busy_a, 0);
      checkOutput("midrst_remaining2", rem_b, 2);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postrst_busy", busy_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
